// File: rtl/counter_seq_pkg.sv
// ---------------------------------------------------------------------------
// counter_seq_pkg
//   Shared definitions for the counter sequencer:
//     seq_state_t  - sequencer state (IDLE, RUN, PAUSED, DONE), 2 bits
//     WIDTH_DEF    - default counter / limit width
//     EVT_W_DEF    - default width of the saturating period counter
//     PERIOD_SAT   - saturation value of the period counter at default width
// ---------------------------------------------------------------------------
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int EVT_W_DEF = 8;

    localparam logic [EVT_W_DEF-1:0] PERIOD_SAT = {EVT_W_DEF{1'b1}};

endpackage

// File: rtl/en_clr_counter.sv
// ---------------------------------------------------------------------------
// en_clr_counter
//   Free-running up counter with synchronous clear and count enable.
//   Clear has priority over enable.
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-low reset
//   en     in   1      increment by one on the next edge
//   clr    in   1      force count to zero on the next edge
//   count  out  WIDTH  registered count value
// ---------------------------------------------------------------------------
module en_clr_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//   Programmable interval controller. Loads a terminal limit over a
//   valid/ready handshake, then sequences an enable/clear counter in
//   one-shot or periodic mode with pause, stop and restart.
// Ports
//   clk           in   1      system clock, rising edge
//   rst           in   1      asynchronous, active-low reset
//   cfg_valid     in   1      config request
//   cfg_ready     out  1      config accepted when valid & ready (IDLE/DONE)
//   cfg_limit     in   WIDTH  terminal count value (inclusive)
//   cfg_periodic  in   1      1 = auto-reload, 0 = one-shot
//   start         in   1      single-cycle start pulse
//   stop          in   1      single-cycle abort pulse
//   pause         in   1      level: hold count while high
//   count         out  WIDTH  current count
//   tick          out  1      one-cycle pulse after terminal count
//   busy          out  1      state is RUN or PAUSED
//   done          out  1      sticky, one-shot complete
//   periods       out  EVT_W  terminal counts since start, saturating
// ---------------------------------------------------------------------------
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int EVT_W = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [EVT_W-1:0] periods
);

    localparam logic [EVT_W-1:0] PERIODS_MAX = {EVT_W{1'b1}};

    seq_state_t       state_reg;
    logic [WIDTH-1:0] limit_reg;
    logic             periodic_reg;
    logic             tick_reg;
    logic             done_reg;
    logic [EVT_W-1:0] periods_reg;

    logic             idle_or_done;
    logic             cfg_accept;
    logic             stop_act;
    logic             start_act;
    logic             terminal;
    logic             cnt_en;
    logic             cnt_clr;

    // Edge decode. Stop only acts outside IDLE and blocks a same-cycle start;
    // start is only honoured from IDLE/DONE, so it can never restart a run.
    assign idle_or_done = (state_reg == IDLE) || (state_reg == DONE);
    assign cfg_accept   = cfg_valid && idle_or_done;
    assign stop_act     = stop && !idle_or_done || stop && (state_reg == DONE);
    assign start_act    = start && !stop && idle_or_done;

    // Pause wins over the terminal compare; the terminal edge is retaken
    // once the sequencer is back in RUN with pause low.
    assign terminal = (state_reg == RUN) && !stop && !pause && (count == limit_reg);

    // Counter controls: any restart, abort or wrap clears; plain RUN counts.
    assign cnt_clr = stop_act || start_act || terminal;
    assign cnt_en  = (state_reg == RUN) && !stop && !pause && !terminal;

    en_clr_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            limit_reg    <= '0;
            periodic_reg <= 1'b0;
            tick_reg     <= 1'b0;
            done_reg     <= 1'b0;
            periods_reg  <= '0;
        end else begin
            tick_reg <= 1'b0;

            // The handshake completes whenever valid meets ready, so the
            // latch happens even alongside a stop from DONE.
            if (cfg_accept) begin
                limit_reg    <= cfg_limit;
                periodic_reg <= cfg_periodic;
                done_reg     <= 1'b0;
            end

            if (stop_act) begin
                // periods is deliberately held for readout after an abort
                state_reg <= IDLE;
                done_reg  <= 1'b0;
            end else begin
                unique case (state_reg)
                    IDLE, DONE: begin
                        if (start_act) begin
                            state_reg   <= RUN;
                            periods_reg <= '0;
                            done_reg    <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state_reg <= PAUSED;
                        end else if (terminal) begin
                            tick_reg <= 1'b1;
                            if (periods_reg != PERIODS_MAX) begin
                                periods_reg <= periods_reg + EVT_W'(1);
                            end
                            if (!periodic_reg) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        // The resume edge only changes state; counting
                        // restarts on the following RUN edge.
                        if (!pause) begin
                            state_reg <= RUN;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign tick      = tick_reg;
    assign done      = done_reg;
    assign periods   = periods_reg;
    assign busy      = (state_reg == RUN) || (state_reg == PAUSED);
    assign cfg_ready = idle_or_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//   Directed stimulus for counter_sequencer. A flag-level behavioural model
//   tracks what every output must be each cycle; literal checks pin the
//   model at the interesting points of each scenario.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int WIDTH = 32;
    localparam int EVT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_limit = '0;
    logic             cfg_periodic = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pause = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;
    logic [EVT_W-1:0] periods;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: active = a run is in progress (running or paused),
    // frozen = paused, plus the visible registered outputs.
    logic [31:0] m_count  = '0;
    logic [31:0] m_limit  = '0;
    bit          m_per    = 1'b0;
    bit          m_active = 1'b0;
    bit          m_frozen = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_tick   = 1'b0;
    int          m_periods = 0;

    counter_sequencer #(
        .WIDTH (WIDTH),
        .EVT_W (EVT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .count        (count),
        .tick         (tick),
        .busy         (busy),
        .done         (done),
        .periods      (periods)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = '0;
        m_limit   = '0;
        m_per     = 1'b0;
        m_active  = 1'b0;
        m_frozen  = 1'b0;
        m_done    = 1'b0;
        m_tick    = 1'b0;
        m_periods = 0;
    endtask

    task automatic model_step();
        bit ready_m;
        ready_m = !m_active;
        m_tick  = 1'b0;
        if (cfg_valid && ready_m) begin
            m_limit = cfg_limit;
            m_per   = cfg_periodic;
            m_done  = 1'b0;
        end
        if (stop) begin
            m_active = 1'b0;
            m_frozen = 1'b0;
            m_count  = '0;
            m_done   = 1'b0;
        end else if (start && ready_m) begin
            m_active  = 1'b1;
            m_frozen  = 1'b0;
            m_count   = '0;
            m_periods = 0;
            m_done    = 1'b0;
        end else if (m_active && m_frozen) begin
            if (!pause) m_frozen = 1'b0;
        end else if (m_active) begin
            if (pause) begin
                m_frozen = 1'b1;
            end else if (m_count == m_limit) begin
                m_count = '0;
                m_tick  = 1'b1;
                if (m_periods < 255) m_periods = m_periods + 1;
                if (!m_per) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else begin
                m_count = m_count + 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) model_step();
    end

    initial forever begin
        @(negedge rst);
        model_reset();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("count",     count,               m_count);
            chk("tick",      32'(tick),           32'(m_tick));
            chk("busy",      32'(busy),           32'(m_active));
            chk("done",      32'(done),           32'(m_done));
            chk("periods",   32'(periods),        32'(m_periods));
            chk("cfg_ready", 32'(cfg_ready),      32'(!m_active));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Config and start in the same cycle: start must use the new values.
    task automatic go(input logic [31:0] lim, input bit per);
        cfg_valid    = 1'b1;
        cfg_limit    = lim;
        cfg_periodic = per;
        start        = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst    = 1'b1;
        chk_on = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_periods", 32'(periods), 0);
        $display("[%0t] reset released", $time);

        // 1: one-shot, limit 4
        go(4, 1'b0);
        chk("t1_first", count, 0);
        cyc(5);
        chk("t1_count", count, 0);
        chk("t1_tick", 32'(tick), 1);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_periods", 32'(periods), 1);
        cyc(1);
        chk("t1_tick_once", 32'(tick), 0);
        chk("t1_done_sticky", 32'(done), 1);
        $display("[%0t] one-shot limit=4 complete", $time);

        // 2: periodic, limit 2, 9 cycles
        go(2, 1'b1);
        cyc(9);
        chk("t2_periods", 32'(periods), 3);
        chk("t2_tick", 32'(tick), 1);
        chk("t2_done", 32'(done), 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t2_stop_periods", 32'(periods), 3);
        chk("t2_stop_busy", 32'(busy), 0);
        $display("[%0t] periodic limit=2 complete", $time);

        // 3: pause at count 5, limit 9
        go(9, 1'b0);
        cyc(5);
        chk("t3_pre", count, 5);
        pause = 1'b1;
        cyc(3);
        chk("t3_hold", count, 5);
        chk("t3_busy", 32'(busy), 1);
        pause = 1'b0;
        cyc(2);
        chk("t3_resume", count, 6);
        cyc(4);
        chk("t3_done", 32'(done), 1);
        $display("[%0t] pause scenario complete", $time);

        // pause exactly at the terminal edge
        go(2, 1'b0);
        cyc(2);
        pause = 1'b1;
        cyc(2);
        chk("pt_tick", 32'(tick), 0);
        chk("pt_count", count, 2);
        pause = 1'b0;
        cyc(1);
        chk("pt_resume_done", 32'(done), 0);
        cyc(1);
        chk("pt_tick_after", 32'(tick), 1);
        chk("pt_done_after", 32'(done), 1);
        $display("[%0t] pause-at-terminal complete", $time);

        // 4: asynchronous reset mid-run
        go(20, 1'b1);
        cyc(7);
        chk("t4_pre", count, 7);
        #2 rst = 1'b0;
        #1;
        chk("t4_count", count, 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_tick", 32'(tick), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_ready", 32'(cfg_ready), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        $display("[%0t] async reset complete", $time);

        // 5: cfg during RUN is refused; start during RUN ignored; stop+start
        go(10, 1'b0);
        cfg_valid    = 1'b1;
        cfg_limit    = 3;
        cfg_periodic = 1'b1;
        #0 chk("t5_ready", 32'(cfg_ready), 0);
        cyc(1);
        cfg_valid = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("t5_limit_kept", count, 6);
        stop  = 1'b1;
        start = 1'b1;
        cyc(1);
        stop  = 1'b0;
        start = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_count", count, 0);
        $display("[%0t] cfg-in-run and stop+start complete", $time);

        // 6: limit 0 one-shot, then limit 0 periodic saturating
        go(0, 1'b0);
        chk("t6_os_busy", 32'(busy), 1);
        cyc(1);
        chk("t6_os_done", 32'(done), 1);
        go(0, 1'b1);
        cyc(1);
        chk("t6_tick1", 32'(tick), 1);
        chk("t6_per1", 32'(periods), 1);
        cyc(1);
        chk("t6_per2", 32'(periods), 2);
        cyc(260);
        chk("t6_sat", 32'(periods), 255);
        chk("t6_tick", 32'(tick), 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t6_stop_periods", 32'(periods), 255);
        $display("[%0t] limit=0 scenarios complete", $time);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
